// File: rtl/vga_sync_gen.sv
// ============================================================================
// vga_sync_gen
// ----------------------------------------------------------------------------
// VGA timing generator. Divides clk down to a pixel tick and runs horizontal
// and vertical pixel counters. From those counts it produces the sync pulses,
// the visible-area flag and the coordinates that the bitmap generator uses to
// address video RAM.
//
// Default timing is 640x480 at 60 Hz from a 50 MHz clk (CLK_DIV = 2):
//   H_TOTAL = 640 + 16 + 96 + 48 = 800 pixels per line
//   V_TOTAL = 480 + 10 +  2 + 33 = 525 lines per frame
//
// Ports:
//   clk         in   1   system clock
//   reset       in   1   asynchronous, active-high reset
//   p_tick      out  1   one-clk pulse per pixel
//   pix_x       out  10  horizontal count, 0..H_TOTAL-1
//   pix_y       out  10  vertical count, 0..V_TOTAL-1
//   video_on    out  1   high inside the visible area
//   hsync       out  1   horizontal sync, active-low
//   vsync       out  1   vertical sync, active-low
//   line_tick   out  1   one-clk pulse on the last pixel of each line
//   frame_tick  out  1   one-clk pulse on the last pixel of each frame
//
// Build option:
//   VGA_SYNC_DELAY_EN  When defined, hsync, vsync and video_on pass through
//                      one extra register stage enabled by p_tick, so they lag
//                      pix_x/pix_y by exactly one pixel. This lines them up
//                      with data coming out of a synchronous video RAM that
//                      has one cycle of read latency. The extra stage resets
//                      to hsync=1, vsync=1, video_on=0.
//                      When undefined, the sync outputs and video_on line up
//                      with pix_x/pix_y.
//
// All counts are 10 bits wide. Every parameter total must be <= 1024.
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,    // clk cycles per pixel, >= 1
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_RETRACE = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_RETRACE = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VISIBLE  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    // A CLK_DIV of 1 still needs a one-bit divider register to keep the
    // declarations legal; it simply stays at zero.
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_next;
    logic             r_p_tick;

    logic [9:0]       r_pix_x;
    logic [9:0]       r_pix_y;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;

    logic             r_hsync;
    logic             r_vsync;
    logic             w_hsync_next;
    logic             w_vsync_next;

    logic             w_video_on;
    logic             w_line_tick;
    logic             w_frame_tick;

    // ------------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------------
    // The pixel tick is registered from the divider's next value, so p_tick is
    // high exactly while the divider holds CLK_DIV-1. After reset the first
    // pixel advance therefore lands CLK_DIV clk edges later.
    always_comb begin
        if (r_div_cnt == DIV_LAST) begin
            w_div_next = '0;
        end else begin
            w_div_next = r_div_cnt + DIV_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_p_tick  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_p_tick  <= (w_div_next == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------------
    // Pixel counters
    // ------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves a value unassigned and infers a latch.
    always_comb begin
        w_x_next = r_pix_x;
        w_y_next = r_pix_y;
        if (r_p_tick) begin
            if (r_pix_x == H_LAST) begin
                w_x_next = '0;
                if (r_pix_y == V_LAST) begin
                    w_y_next = '0;
                end else begin
                    w_y_next = r_pix_y + 10'd1;
                end
            end else begin
                w_x_next = r_pix_x + 10'd1;
            end
        end
    end

    // Sync levels are decoded from the next counts and registered alongside
    // the counters, so they switch on the same clk edge as pix_x/pix_y and
    // come straight from flops without decode glitches.
    always_comb begin
        w_hsync_next = !((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST));
        w_vsync_next = !((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_x <= '0;
            r_pix_y <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_pix_x <= w_x_next;
            r_pix_y <= w_y_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
        end
    end

    // ------------------------------------------------------------------------
    // Decoded flags
    // ------------------------------------------------------------------------
    // The ticks are gated by p_tick so they last one clk even though the
    // counts hold their value for CLK_DIV clks.
    always_comb begin
        w_video_on   = (r_pix_x < H_VISIBLE) && (r_pix_y < V_VISIBLE);
        w_line_tick  = r_p_tick && (r_pix_x == H_LAST);
        w_frame_tick = w_line_tick && (r_pix_y == V_LAST);
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
`ifdef VGA_SYNC_DELAY_EN
    // One pixel of delay on the display-side signals to match the read
    // latency of the video RAM. Each stage loads on the pixel tick, so it
    // holds the previous pixel's value for the whole current pixel.
    logic r_hsync_d;
    logic r_vsync_d;
    logic r_video_on_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync_d    <= 1'b1;
            r_vsync_d    <= 1'b1;
            r_video_on_d <= 1'b0;
        end else if (r_p_tick) begin
            r_hsync_d    <= r_hsync;
            r_vsync_d    <= r_vsync;
            r_video_on_d <= w_video_on;
        end
    end

    assign hsync    = r_hsync_d;
    assign vsync    = r_vsync_d;
    assign video_on = r_video_on_d;
`else
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = w_video_on;
`endif

    assign p_tick     = r_p_tick;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign line_tick  = w_line_tick;
    assign frame_tick = w_frame_tick;

endmodule
